bus_fsm_multiword: RTL
======================

# bus_fsm_multiword

Parametrised next-generation bus interface FSM for a peripheral subsystem on the 32-bit handshake bus. It receives a configurable number of command words per transaction. For read transactions it returns a configurable number of data words, followed by an optional status word. A handshake watchdog and a mid-transaction abort on enable loss are included. It sits between the shared bus pins and the subsystem's register/datapath logic, which consumes the strobe and index outputs.

## Interface
- N_RX_WORDS, 1 — command words received per transaction (1..8).
- N_TX_WORDS, 1 — data words returned on a read transaction (1..8).
- STATUS_RETURN, 1 — 1: a status word follows the data words; 0: no status word.
- TIMEOUT_CYCLES, 1024 — maximum cycles spent in any handshake wait state; 0 disables the watchdog. Counter width is 16 bits.
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- RW  input  1  transaction type, sampled in S_RX_LATCH of word 0 only: 1 = read (data returned), 0 = write.
- subsystem_enable  input  1  subsystem select from bus master.
- handshake_1  input  1  master strobe.
- handshake_2  output  1  slave acknowledge; tristate.
- read_word_from_BUS  output  1  one-cycle strobe; the bus word is latched into the register selected by rx_word_index.
- rx_word_index  output  3  index of the command word being received (0..N_RX_WORDS-1).
- write_data_word_to_BUS  output  1  drive data word tx_word_index onto the bus.
- tx_word_index  output  3  index of the data word being driven (0..N_TX_WORDS-1).
- write_status_word_to_BUS  output  1  drive the status word onto the bus.
- rw_latched  output  1  RW value captured at word 0.
- timeout_error  output  1  one-cycle pulse when the watchdog fires.
- abort  output  1  one-cycle pulse on enable loss mid-transaction.
- busy  output  1  high in every state except S_IDLE.

## Operation
- Moore FSM. All outputs decode registered state and counters, except the handshake_2 tristate, which also decodes subsystem_enable.
- States and transitions:
  - S_IDLE → S_RX_WAIT when subsystem_enable = 1.
  - S_RX_WAIT → S_RX_LATCH when handshake_1 = 1.
  - S_RX_LATCH: read_word_from_BUS = 1. On word 0, rw_latched ← RW. → S_RX_ACK.
  - S_RX_ACK: handshake_2 = 1. → S_RX_RELEASE.
  - S_RX_RELEASE: wait for handshake_1 = 0, then:
    - if rx_word_index < N_RX_WORDS-1: increment rx_word_index, → S_RX_WAIT;
    - else if rw_latched: → S_TX_SETUP;
    - else if STATUS_RETURN: → S_ST_SETUP;
    - else: → S_DONE.
  - S_TX_SETUP: write_data_word_to_BUS = 1. → S_TX_READY.
  - S_TX_READY: write_data_word_to_BUS = 1, handshake_2 = 1. → S_TX_HOLD when handshake_1 = 1.
  - S_TX_HOLD: bus drive off, handshake_2 = 0. Wait for handshake_1 = 0, then:
    - next data word (increment tx_word_index) → S_TX_SETUP;
    - after the last word → S_ST_SETUP if STATUS_RETURN, else → S_DONE.
  - S_ST_SETUP / S_ST_READY / S_ST_HOLD: identical to the three TX states, using write_status_word_to_BUS. S_ST_HOLD exits → S_DONE.
  - S_DONE → S_IDLE when subsystem_enable = 0.
- Both indices clear in S_IDLE and on entry to S_TX_SETUP from the RX phase.
- handshake_2:
  - 1 in S_RX_ACK, S_TX_READY and S_ST_READY;
  - otherwise 0 if subsystem_enable = 1;
  - otherwise high-Z.
- Watchdog:
  - Counts in S_RX_WAIT (except word 0), S_RX_RELEASE, S_TX_READY, S_TX_HOLD, S_ST_READY and S_ST_HOLD. Clears on every state change.
  - On reaching TIMEOUT_CYCLES: timeout_error pulses and the FSM goes to S_DONE.
  - S_RX_WAIT of word 0 is exempt, because the master may delay the first strobe indefinitely.
- Abort: subsystem_enable = 0 in any state other than S_IDLE/S_DONE → abort pulses, FSM goes to S_IDLE. Abort has priority over timeout and normal transitions.
- Reset: state S_IDLE. All counters, indices and rw_latched are 0. All strobe/pulse outputs are 0 and busy = 0. handshake_2 follows the enable rule (Z when enable = 0). Reset mid-transaction takes effect on the next clock edge, unconditionally.

## Timing
- Enable → S_RX_WAIT: 1 cycle.
- handshake_1 rise → read_word_from_BUS high: 1 cycle (S_RX_LATCH). handshake_2 high in the following cycle, for exactly 1 cycle.
- handshake_1 fall → next S_RX_WAIT: 1 cycle.
- TX word: bus driven for ≥ 1 cycle (S_TX_SETUP) before handshake_2 rises. The drive and handshake_2 drop together 1 cycle after handshake_1 rises.
- Minimum per RX word, with an immediate master: 4 cycles. Minimum per TX/status word: 3 cycles.
- Watchdog fires on the TIMEOUT_CYCLES-th consecutive cycle spent in one wait state. timeout_error is high in the cycle S_DONE is entered.

## Test plan
- N_RX=3, N_TX=2, STATUS=1, RW=1: full handshake. Expect read_word_from_BUS with indices 0,1,2, then data with tx_word_index 0,1, then the status word, then S_DONE. busy drops 1 cycle after enable falls.
- N_RX=2, RW=0, STATUS=0: expect two RX strobes. write_data_word_to_BUS and write_status_word_to_BUS never assert. FSM parks in S_DONE.
- TIMEOUT_CYCLES=16: master holds handshake_1 high after RX word 0. Expect timeout_error pulse exactly 16 cycles after S_RX_RELEASE entry, then S_DONE. Also stall word-0 S_RX_WAIT for 100 cycles → no timeout.
- Drop subsystem_enable during S_TX_READY of word 1. Expect abort pulse, S_IDLE next cycle, handshake_2 = Z, indices 0.
- Assert reset during S_RX_ACK. Expect all outputs 0 and handshake_2 = Z (enable = 0) the next cycle. Then a clean transaction succeeds.
- N_RX=1, N_TX=1, STATUS=0: check the minimum cycle counts in ## Timing, with handshake_1 toggled with zero master delay.

Source files
------------

// File: rtl/bus_fsm_multiword_if.sv
// Bus-side signal bundle for bus_fsm_multiword.
// The master modport is the bus master / testbench side; the slave modport
// is the FSM. The tristate acknowledge pin (handshake_2) is a plain port on
// the FSM so it resolves at the pad level.
interface bus_fsm_multiword_if;
    logic       RW;
    logic       subsystem_enable;
    logic       handshake_1;
    logic       read_word_from_BUS;
    logic [2:0] rx_word_index;
    logic       write_data_word_to_BUS;
    logic [2:0] tx_word_index;
    logic       write_status_word_to_BUS;
    logic       rw_latched;
    logic       timeout_error;
    logic       abort;
    logic       busy;

    modport master (
        output RW, subsystem_enable, handshake_1,
        input  read_word_from_BUS, rx_word_index, write_data_word_to_BUS,
               tx_word_index, write_status_word_to_BUS, rw_latched,
               timeout_error, abort, busy
    );

    modport slave (
        input  RW, subsystem_enable, handshake_1,
        output read_word_from_BUS, rx_word_index, write_data_word_to_BUS,
               tx_word_index, write_status_word_to_BUS, rw_latched,
               timeout_error, abort, busy
    );
endinterface

// File: rtl/bus_fsm_multiword.sv
// Multi-word handshake bus slave FSM.
// Receives N_RX_WORDS command words, optionally returns N_TX_WORDS data words
// (read transactions) and an optional status word. Includes a per-wait-state
// watchdog and an abort on loss of subsystem_enable mid-transaction.
// Moore machine: every output decodes registered state, except the
// handshake_2 tristate enable which also looks at subsystem_enable.
module bus_fsm_multiword #(
    parameter int N_RX_WORDS     = 1,
    parameter int N_TX_WORDS     = 1,
    parameter bit STATUS_RETURN  = 1'b1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    bus_fsm_multiword_if.slave    bus,
    output wire                   handshake_2
);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_RX_WAIT    = 4'd1,
        S_RX_LATCH   = 4'd2,
        S_RX_ACK     = 4'd3,
        S_RX_RELEASE = 4'd4,
        S_TX_SETUP   = 4'd5,
        S_TX_READY   = 4'd6,
        S_TX_HOLD    = 4'd7,
        S_ST_SETUP   = 4'd8,
        S_ST_READY   = 4'd9,
        S_ST_HOLD    = 4'd10,
        S_DONE       = 4'd11
    } state_t;

    localparam logic [2:0]  RX_LAST = 3'(N_RX_WORDS - 1);
    localparam logic [2:0]  TX_LAST = 3'(N_TX_WORDS - 1);
    localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);
    // Counter value seen during the TIMEOUT_CYCLES-th cycle in a wait state.
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [2:0]  rx_idx_q, rx_idx_d;
    logic [2:0]  tx_idx_q, tx_idx_d;
    logic        rw_q, rw_d;
    logic [15:0] wd_q, wd_d;
    logic        timeout_q, timeout_d;
    logic        abort_q, abort_d;
    logic        wd_counting;
    logic        hs2_drive_one;

    // Handshake wait states guarded by the watchdog. Word-0 RX_WAIT is
    // exempt: the master may hold off the first strobe indefinitely.
    assign wd_counting = ((state_q == S_RX_WAIT) && (rx_idx_q != 3'd0)) ||
                         (state_q == S_RX_RELEASE) ||
                         (state_q == S_TX_READY)   || (state_q == S_TX_HOLD) ||
                         (state_q == S_ST_READY)   || (state_q == S_ST_HOLD);

    // State, index, latch and watchdog registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            rx_idx_q  <= '0;
            tx_idx_q  <= '0;
            rw_q      <= 1'b0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_idx_q  <= rx_idx_d;
            tx_idx_q  <= tx_idx_d;
            rw_q      <= rw_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
            abort_q   <= abort_d;
        end
    end

    // Next-state logic: normal protocol, then watchdog, then abort (highest).
    always_comb begin
        state_d   = state_q;
        rx_idx_d  = rx_idx_q;
        tx_idx_d  = tx_idx_q;
        rw_d      = rw_q;
        timeout_d = 1'b0;
        abort_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.subsystem_enable) state_d = S_RX_WAIT;
            end
            S_RX_WAIT: begin
                if (bus.handshake_1) state_d = S_RX_LATCH;
            end
            S_RX_LATCH: begin
                if (rx_idx_q == 3'd0) rw_d = bus.RW;
                state_d = S_RX_ACK;
            end
            S_RX_ACK: begin
                state_d = S_RX_RELEASE;
            end
            S_RX_RELEASE: begin
                if (!bus.handshake_1) begin
                    if (rx_idx_q < RX_LAST) begin
                        rx_idx_d = rx_idx_q + 3'd1;
                        state_d  = S_RX_WAIT;
                    end else if (rw_q) begin
                        // Data phase restarts both indices from zero.
                        rx_idx_d = '0;
                        tx_idx_d = '0;
                        state_d  = S_TX_SETUP;
                    end else if (STATUS_RETURN) begin
                        state_d = S_ST_SETUP;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_TX_SETUP: begin
                state_d = S_TX_READY;
            end
            S_TX_READY: begin
                if (bus.handshake_1) state_d = S_TX_HOLD;
            end
            S_TX_HOLD: begin
                if (!bus.handshake_1) begin
                    if (tx_idx_q < TX_LAST) begin
                        tx_idx_d = tx_idx_q + 3'd1;
                        state_d  = S_TX_SETUP;
                    end else if (STATUS_RETURN) begin
                        state_d = S_ST_SETUP;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ST_SETUP: begin
                state_d = S_ST_READY;
            end
            S_ST_READY: begin
                if (bus.handshake_1) state_d = S_ST_HOLD;
            end
            S_ST_HOLD: begin
                if (!bus.handshake_1) state_d = S_DONE;
            end
            S_DONE: begin
                if (!bus.subsystem_enable) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Watchdog only fires while the FSM is still stuck in the wait state;
        // a handshake arriving in the last allowed cycle wins.
        if (WD_EN && wd_counting && (state_d == state_q) && (wd_q == WD_LAST)) begin
            state_d   = S_DONE;
            timeout_d = 1'b1;
        end

        if (!bus.subsystem_enable && (state_q != S_IDLE) && (state_q != S_DONE)) begin
            state_d   = S_IDLE;
            abort_d   = 1'b1;
            timeout_d = 1'b0;
        end

        // Indices read zero in the very cycle IDLE is entered.
        if (state_d == S_IDLE) begin
            rx_idx_d = '0;
            tx_idx_d = '0;
        end

        // Counter holds the number of cycles already spent in this state.
        if ((state_d != state_q) || !wd_counting) wd_d = '0;
        else                                      wd_d = wd_q + 16'd1;
    end

    // Output decode from registered state.
    assign bus.read_word_from_BUS       = (state_q == S_RX_LATCH);
    assign bus.write_data_word_to_BUS   = (state_q == S_TX_SETUP) || (state_q == S_TX_READY);
    assign bus.write_status_word_to_BUS = (state_q == S_ST_SETUP) || (state_q == S_ST_READY);
    assign bus.rx_word_index            = rx_idx_q;
    assign bus.tx_word_index            = tx_idx_q;
    assign bus.rw_latched               = rw_q;
    assign bus.timeout_error            = timeout_q;
    assign bus.abort                    = abort_q;
    assign bus.busy                     = (state_q != S_IDLE);

    // Acknowledge: driven high in the ack/ready states, driven low while
    // selected, released otherwise so other slaves can share the pin.
    assign hs2_drive_one = (state_q == S_RX_ACK) || (state_q == S_TX_READY) ||
                           (state_q == S_ST_READY);
    assign handshake_2   = hs2_drive_one          ? 1'b1 :
                           bus.subsystem_enable   ? 1'b0 : 1'bz;

endmodule
